// File: rtl/display_source_select_pkg.sv
// Shared constants and state type for the display source selector.
package display_source_select_pkg;

  localparam int SEL_W = 3;
  localparam logic [7:0] HEX_BLANK = 8'hFF;
  localparam logic LED_OFF = 1'b0;

  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } disp_state_e;

endpackage

// File: rtl/key_debounce.sv
// Debounces an already-synchronised active-low key and emits a one-cycle
// press pulse on the debounced high-to-low transition.
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int CNT_LAST_I = DEB_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             press_r;

  // Count consecutive cycles the input disagrees with the debounced level
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= 1'b1;
      press_r <= 1'b0;
    end else if (raw == level_r) begin
      cnt_r   <= {CNT_W{1'b0}};
      press_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= raw;
      press_r <= ~raw;
    end else begin
      cnt_r   <= cnt_r + 1'b1;
      press_r <= 1'b0;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/display_source_select.sv
// Selects one of NUM_SRC LED / seven-segment buses, cycled by a pushbutton or
// indexed by switches, inserting a blanking gap on every source change.
module display_source_select
  import display_source_select_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int LED_W        = 10,
  parameter int HEX_N        = 6,
  parameter int DEB_CYCLES   = 500000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                       MAX10_CLK1_50,
  input  logic                       RST,
  input  logic                       KEY_NEXT,
  input  logic                       SEL_DIRECT,
  input  logic [2:0]                 SW_SEL,
  input  logic [NUM_SRC*LED_W-1:0]   SRC_LEDS,
  input  logic [NUM_SRC*HEX_N*8-1:0] SRC_HEX,
  output logic [LED_W-1:0]           LEDR,
  output logic [HEX_N*8-1:0]         HEX,
  output logic [2:0]                 CUR_SEL
);

  localparam int HEX_W = HEX_N * 8;
  localparam int BC_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int BLANK_LAST = BLANK_CYCLES - 1;
  localparam logic [BC_W-1:0] BLANK_LOAD = BLANK_LAST[BC_W-1:0];
  localparam int LAST_SRC = NUM_SRC - 1;
  localparam logic [SEL_W-1:0] LAST_IDX = LAST_SRC[SEL_W-1:0];
  localparam logic [SEL_W:0] SRC_COUNT = NUM_SRC[SEL_W:0];

  logic              key_meta_r, key_sync_r;
  logic [SEL_W-1:0]  sw_meta_r, sw_sync_r, sw_clamp_s;
  logic              key_level_s, key_press_s;
  logic              direct_prev_r;
  disp_state_e       state_r, state_nxt_s;
  logic [BC_W-1:0]   blank_cnt_r, blank_cnt_nxt_s;
  logic [SEL_W-1:0]  disp_r, disp_nxt_s, target_r, target_nxt_s;
  logic [LED_W-1:0]  led_r;
  logic [HEX_W-1:0]  hex_r;

  // Two-flop synchronisers for the asynchronous key and switch inputs
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      key_meta_r <= 1'b1;
      key_sync_r <= 1'b1;
      sw_meta_r  <= {SEL_W{1'b1}};
      sw_sync_r  <= {SEL_W{1'b1}};
    end else begin
      key_meta_r <= KEY_NEXT;
      key_sync_r <= key_meta_r;
      sw_meta_r  <= SW_SEL;
      sw_sync_r  <= sw_meta_r;
    end
  end

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key_debounce (
    .clock(MAX10_CLK1_50),
    .reset(RST),
    .raw  (key_sync_r),
    .level(key_level_s),
    .press(key_press_s)
  );

  // Clamp the switch index into the legal source range
  always_comb begin
    sw_clamp_s = sw_sync_r;
    if ({1'b0, sw_sync_r} >= SRC_COUNT) begin
      sw_clamp_s = LAST_IDX;
    end else begin
      sw_clamp_s = sw_sync_r;
    end
  end

  // Target index: switches in direct mode, otherwise stepped by presses;
  // leaving direct mode resumes cycling from what is on screen
  always_comb begin
    target_nxt_s = target_r;
    if (SEL_DIRECT) begin
      target_nxt_s = sw_clamp_s;
    end else if (direct_prev_r) begin
      target_nxt_s = disp_r;
    end else if (key_press_s && !key_level_s) begin
      target_nxt_s = (target_r == LAST_IDX) ? {SEL_W{1'b0}} : target_r + 1'b1;
    end else begin
      target_nxt_s = target_r;
    end
  end

  // Show/blank sequencing; the blank counter is never reloaded mid-blank
  always_comb begin
    state_nxt_s     = state_r;
    blank_cnt_nxt_s = blank_cnt_r;
    disp_nxt_s      = disp_r;
    case (state_r)
      SHOW: begin
        if (target_r != disp_r) begin
          state_nxt_s     = BLANK;
          blank_cnt_nxt_s = BLANK_LOAD;
        end else begin
          state_nxt_s     = SHOW;
        end
      end
      BLANK: begin
        if (blank_cnt_r == {BC_W{1'b0}}) begin
          state_nxt_s = SHOW;
          disp_nxt_s  = target_r;
        end else begin
          blank_cnt_nxt_s = blank_cnt_r - 1'b1;
        end
      end
      default: begin
        state_nxt_s     = SHOW;
        blank_cnt_nxt_s = {BC_W{1'b0}};
      end
    endcase
  end

  // Selection state and registered outputs, driven from the next state so
  // blanking and the new source appear on the same edge as the transition
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      state_r       <= SHOW;
      blank_cnt_r   <= {BC_W{1'b0}};
      disp_r        <= {SEL_W{1'b0}};
      target_r      <= {SEL_W{1'b0}};
      direct_prev_r <= 1'b0;
      led_r         <= {LED_W{LED_OFF}};
      hex_r         <= {HEX_N{HEX_BLANK}};
    end else begin
      state_r       <= state_nxt_s;
      blank_cnt_r   <= blank_cnt_nxt_s;
      disp_r        <= disp_nxt_s;
      target_r      <= target_nxt_s;
      direct_prev_r <= SEL_DIRECT;
      if (state_nxt_s == BLANK) begin
        led_r <= {LED_W{LED_OFF}};
        hex_r <= {HEX_N{HEX_BLANK}};
      end else begin
        led_r <= SRC_LEDS[disp_nxt_s*LED_W +: LED_W];
        hex_r <= SRC_HEX[disp_nxt_s*HEX_W +: HEX_W];
      end
    end
  end

  assign LEDR    = led_r;
  assign HEX     = hex_r;
  assign CUR_SEL = disp_r;

endmodule

// File: tb/tb_display_source_select.sv
// Self-checking bench for display_source_select: directed sequences, a vector
// table for direct mode and a randomized phase checked by an invariant monitor.
`timescale 1ns/1ps
module tb_display_source_select;

  localparam int NUM_SRC   = 4;
  localparam int LED_W     = 10;
  localparam int HEX_N     = 6;
  localparam int HW        = HEX_N * 8;
  localparam int DEB       = 8;
  localparam int BLANK_LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key = 1'b1;
  logic sel_direct = 1'b0;
  logic [2:0] sw_sel = 3'd0;
  logic [NUM_SRC*LED_W-1:0] src_leds;
  logic [NUM_SRC*HW-1:0]    src_hex;
  logic [LED_W-1:0] ledr;
  logic [HW-1:0]    hex;
  logic [2:0]       cur_sel;

  always #10 clk = ~clk;

  display_source_select #(
    .NUM_SRC(NUM_SRC), .LED_W(LED_W), .HEX_N(HEX_N),
    .DEB_CYCLES(DEB), .BLANK_CYCLES(BLANK_LEN)
  ) dut (
    .MAX10_CLK1_50(clk), .RST(rst), .KEY_NEXT(key), .SEL_DIRECT(sel_direct),
    .SW_SEL(sw_sel), .SRC_LEDS(src_leds), .SRC_HEX(src_hex),
    .LEDR(ledr), .HEX(hex), .CUR_SEL(cur_sel)
  );

  int checks = 0;
  int errors = 0;

  bit mon_en = 1'b0;
  int run_len, blank_runs, sel_changes, last_run;
  logic [2:0] prev_cur;
  bit prev_blank;
  logic [NUM_SRC*LED_W-1:0] snap_leds;
  logic [NUM_SRC*HW-1:0]    snap_hex;

  typedef struct {
    logic [2:0] sw;
    logic [2:0] exp_sel;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_blank();
    return (ledr == {LED_W{1'b0}}) && (hex == {HEX_N{8'hFF}});
  endfunction

  // One clock: snapshot sources at the edge, then check outputs mid-cycle.
  // Model: outside a blank, outputs equal the selected source as it was at the
  // last edge; blanks last BLANK_LEN cycles; the index only changes as a blank ends.
  task automatic step();
    logic [LED_W-1:0] exp_led;
    logic [HW-1:0] exp_hex;
    bit b;
    @(posedge clk);
    snap_leds = src_leds;
    snap_hex  = src_hex;
    @(negedge clk);
    if (mon_en) begin
      b = is_blank();
      if (b) begin
        run_len++;
      end else begin
        if (run_len > 0) begin
          blank_runs++;
          last_run = run_len;
          check("blank_len", 64'(run_len), 64'(BLANK_LEN));
          run_len = 0;
        end
        exp_led = LED_W'(snap_leds >> (int'(cur_sel) * LED_W));
        exp_hex = HW'(snap_hex >> (int'(cur_sel) * HW));
        check("show_leds", 64'(ledr), 64'(exp_led));
        check("show_hex", 64'(hex), 64'(exp_hex));
      end
      if (cur_sel != prev_cur) begin
        sel_changes++;
        check("sel_change_at_blank_end", 64'({prev_blank, b}), 64'(2'b10));
      end
      prev_cur   = cur_sel;
      prev_blank = b;
    end
  endtask

  task automatic mon_start();
    run_len     = 0;
    blank_runs  = 0;
    sel_changes = 0;
    last_run    = 0;
    prev_cur    = cur_sel;
    prev_blank  = is_blank();
    mon_en      = 1'b1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("rst_leds", 64'(ledr), 64'(0));
    check("rst_hex", 64'(hex), 64'({HEX_N{8'hFF}}));
    check("rst_sel", 64'(cur_sel), 64'(0));
    rst = 1'b0;
    step();
    check("post_rst_leds", 64'(ledr), 64'(src_leds[LED_W-1:0]));
    check("post_rst_hex", 64'(hex), 64'(src_hex[HW-1:0]));
    check("post_rst_sel", 64'(cur_sel), 64'(0));
    mon_start();
  endtask

  task automatic press_key();
    key = 1'b0;
    repeat (14) step();
    key = 1'b1;
    repeat (14) step();
  endtask

  initial begin
    int idx;
    int k;
    logic [7:0] old_d, new_d;
    logic [2:0] exp_sel;

    vecs[0] = '{3'd6, 3'd3};
    vecs[1] = '{3'd0, 3'd0};
    vecs[2] = '{3'd2, 3'd2};
    vecs[3] = '{3'd7, 3'd3};
    vecs[4] = '{3'd1, 3'd1};
    vecs[5] = '{3'd3, 3'd3};
    vecs[6] = '{3'd5, 3'd3};
    vecs[7] = '{3'd4, 3'd3};

    src_leds = {10'h30F, 10'h0F0, 10'h2AA, 10'h155};
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int d = 0; d < HEX_N; d++) begin
        src_hex[s*HW + d*8 +: 8] = 8'(s * 16 + d + 1);
      end
    end

    // Reset with source 0 LEDs = 10'h155
    do_reset();
    check("req033_leds", 64'(ledr), 64'(10'h155));

    // Bouncy press then steady low: exactly one advance
    for (int b = 0; b < 2; b++) begin
      key = 1'b0; repeat (3) step();
      key = 1'b1; repeat (3) step();
    end
    key = 1'b0; repeat (20) step();
    key = 1'b1; repeat (14) step();
    check("bounce_sel_changes", 64'(sel_changes), 64'(1));
    check("bounce_blank_len", 64'(last_run), 64'(BLANK_LEN));
    check("bounce_sel", 64'(cur_sel), 64'(1));

    // Four clean presses from index 0 wrap back to 0
    do_reset();
    idx = 0;
    for (int p = 0; p < 4; p++) begin
      press_key();
      idx = (idx + 1) % NUM_SRC;
      check("press_seq_sel", 64'(cur_sel), 64'(idx));
    end
    check("press_seq_blanks", 64'(blank_runs), 64'(4));

    // Digit 0 of the displayed source propagates with exactly one cycle of latency
    old_d = src_hex[7:0];
    new_d = ~old_d;
    src_hex[7:0] = new_d;
    #1;
    check("hex_not_comb", 64'(hex[7:0]), 64'(old_d));
    step();
    check("hex_digit0_follow", 64'(hex[7:0]), 64'(new_d));

    // Direct-mode vector table
    sel_direct = 1'b1;
    for (int v = 0; v < 8; v++) begin
      sw_sel = vecs[v].sw;
      repeat (12) step();
      check("direct_sel", 64'(cur_sel), 64'(vecs[v].exp_sel));
      check("direct_leds", 64'(ledr), 64'(src_leds[vecs[v].exp_sel*LED_W +: LED_W]));
    end

    // Switch change during a blank: no restart, latest index adopted
    sw_sel = 3'd6;
    repeat (12) step();
    check("sw6_sel", 64'(cur_sel), 64'(3));
    sw_sel = 3'd2;
    for (int i = 0; i < 20 && !is_blank(); i++) step();
    check("sw2_blank_seen", 64'(is_blank()), 64'(1));
    k = sel_changes;
    sw_sel = 3'd1;
    repeat (12) step();
    check("mid_blank_len", 64'(last_run), 64'(BLANK_LEN));
    check("mid_blank_sel", 64'(cur_sel), 64'(1));
    check("mid_blank_one_change", 64'(sel_changes - k), 64'(1));

    // Leaving direct mode continues from the displayed index
    sw_sel = 3'd2;
    repeat (12) step();
    sel_direct = 1'b0;
    repeat (10) step();
    check("mode_exit_no_jump", 64'(cur_sel), 64'(2));
    press_key();
    check("mode_exit_press", 64'(cur_sel), 64'(3));

    // Reset in the middle of a blank
    key = 1'b0;
    for (int i = 0; i < 30 && !is_blank(); i++) step();
    check("rst_blank_seen", 64'(is_blank()), 64'(1));
    mon_en = 1'b0;
    rst = 1'b1;
    key = 1'b1;
    step();
    check("midblank_rst_leds", 64'(ledr), 64'(0));
    check("midblank_rst_hex", 64'(hex), 64'({HEX_N{8'hFF}}));
    check("midblank_rst_sel", 64'(cur_sel), 64'(0));
    rst = 1'b0;
    step();
    check("midblank_post_leds", 64'(ledr), 64'(src_leds[LED_W-1:0]));
    check("midblank_post_sel", 64'(cur_sel), 64'(0));
    mon_start();
    repeat (30) step();
    check("midblank_quiet", 64'(sel_changes), 64'(0));

    // Randomized direct-mode selection with changing source data
    sel_direct = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) sw_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, NUM_SRC - 1);
        src_leds[k*LED_W +: LED_W] = LED_W'($urandom_range(1, 1023));
        src_hex[k*HW +: HW] = HW'({$urandom(), $urandom()});
      end
      step();
    end
    repeat (15) step();
    exp_sel = (sw_sel >= 3'(NUM_SRC)) ? 3'(NUM_SRC - 1) : sw_sel;
    check("random_final_sel", 64'(cur_sel), 64'(exp_sel));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_source_select.md
DISPLAY_SOURCE_SELECT -- requirements
Module: display_source_select

Interface
REQ-001 Parameter NUM_SRC, default 4, number of selectable source designs (legal 2..8).
REQ-002 Parameter LED_W, default 10, LED bus width per source.
REQ-003 Parameter HEX_N, default 6, seven-segment digits per source, 8 bits each, active-low segments.
REQ-004 Parameter DEB_CYCLES, default 500000, debounce stable-time in clock cycles (10 ms at 50 MHz).
REQ-005 Parameter BLANK_CYCLES, default 16, blanking interval on source change.
REQ-006 MAX10_CLK1_50  in  1  sole clock; all state changes on its rising edge.
REQ-007 RST  in  1  reset, synchronous, active-high.
REQ-008 KEY_NEXT  in  1  raw pushbutton, active-low, asynchronous to clock.
REQ-009 SEL_DIRECT  in  1  mode: 1 = index from SW_SEL, 0 = index cycled by KEY_NEXT.
REQ-010 SW_SEL  in  3  direct source index, raw switch, asynchronous.
REQ-011 SRC_LEDS  in  NUM_SRC*LED_W  concatenated source LED buses, source k at [k*LED_W +: LED_W].
REQ-012 SRC_HEX  in  NUM_SRC*HEX_N*8  concatenated source digit buses, source k at [k*HEX_N*8 +: HEX_N*8].
REQ-013 LEDR  out  LED_W  registered selected LED bus.
REQ-014 HEX  out  HEX_N*8  registered selected digits.
REQ-015 CUR_SEL  out  3  currently displayed source index.

Function
REQ-016 KEY_NEXT and SW_SEL shall pass a 2-flop synchroniser before any use.
REQ-017 Synchronised KEY_NEXT shall be debounced: the debounced level changes only after the input holds a new level for DEB_CYCLES consecutive cycles.
REQ-018 A press event shall be one cycle pulse on the debounced high-to-low transition; holding the key yields exactly one event.
REQ-019 Mode SEL_DIRECT=0: each press event increments the target index; index NUM_SRC-1 wraps to 0.
REQ-020 Mode SEL_DIRECT=1: target index = synchronised SW_SEL; values >= NUM_SRC clamp to NUM_SRC-1; press events ignored.
REQ-021 On SEL_DIRECT 1-to-0 transition the cycled index shall start from the current displayed index (no jump).
REQ-022 State machine states: SHOW, BLANK.
REQ-023 SHOW: LEDR/HEX follow the displayed source with one cycle register latency; if target != displayed, go to BLANK and load blank counter with BLANK_CYCLES-1.
REQ-024 BLANK: LEDR = all 0, every HEX digit = 8'hFF; counter decrements each cycle; at 0, displayed index := target, return to SHOW.
REQ-025 Target change during BLANK shall not restart the counter; the latest target at BLANK exit is adopted.
REQ-026 CUR_SEL shall update in the same cycle the FSM enters SHOW with the new index.
REQ-027 Source bus changes in SHOW shall appear on outputs exactly one cycle later; no output shall be driven combinationally from inputs.

Reset
REQ-028 While RST=1 at a clock edge: state SHOW, displayed and target index 0, CUR_SEL=0, LEDR=0, all HEX digits 8'hFF, debounce counter 0, debounced level 1 (released), synchroniser flops 1.
REQ-029 Reset asserted mid-BLANK or mid-debounce shall abort it; first post-reset SHOW output is source 0 one cycle after RST falls.

Structure
REQ-030 Shared package shall hold HEX_BLANK (8'hFF), LED_OFF, the SHOW/BLANK state typedef, and SEL_W = 3.
REQ-031 Debounce plus edge detect shall be a separate sub-module key_debounce (params DEB_CYCLES; ports clock, reset, raw, level, press).
REQ-032 Source selection shall be an indexed part-select on the flattened buses; no per-source generate of output registers.

Verification (bench uses DEB_CYCLES=8, BLANK_CYCLES=4, NUM_SRC=4)
REQ-033 Reset, SEL_DIRECT=0, source 0 LEDs=10'h155 -> LEDR=10'h155 one cycle after RST low, CUR_SEL=0.
REQ-034 KEY_NEXT low with 3-cycle bounces, then steady low 20 cycles -> exactly one press, 4 blank cycles (LEDR=0, HEX all 8'hFF), then CUR_SEL=1.
REQ-035 Four clean presses from index 0 -> CUR_SEL sequence 1,2,3,0.
REQ-036 SEL_DIRECT=1, SW_SEL=6 -> CUR_SEL=3 after synchroniser plus blank; SW_SEL changed to 1 during BLANK -> blank length still 4, CUR_SEL=1.
REQ-037 RST pulsed during BLANK -> next cycle outputs blank-reset values, then source 0, CUR_SEL=0.
REQ-038 In SHOW, toggle SRC_HEX digit 0 of displayed source -> HEX[7:0] follows exactly one cycle later.
